// File: rtl/boreal_csp_weight_loader.sv
// CSP weight loader: buffers a 2x8 weight block and commits it between frames.
// Define CSP_LOADER_CHECKSUM_EN to append a 16-bit wrap-around checksum word.
module boreal_csp_weight_loader #(
  parameter int N_WORDS    = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int HOLD_SETUP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              frame_valid,
  input  logic              filt_out_valid,
  output logic              frame_hold,
  output logic              host_we,
  output logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_weight,
  output logic              load_done,
  output logic              load_err,
  output logic              hold_viol,
  output logic              busy
);

  localparam int IDX_W = $clog2(N_WORDS + 2);
`ifdef CSP_LOADER_CHECKSUM_EN
  localparam int LAST_IDX = N_WORDS;
`else
  localparam int LAST_IDX = N_WORDS - 1;
`endif
  localparam logic [IDX_W-1:0] FINAL = IDX_W'(LAST_IDX);
  localparam logic [IDX_W-1:0] NW = IDX_W'(N_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(N_WORDS - 1);
  localparam int HC_W = $clog2(HOLD_SETUP + 1) + 1;
  localparam int HL = (HOLD_SETUP > 0) ? HOLD_SETUP - 1 : 0;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HL);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    WAIT_IDLE,
    COMMIT,
    DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [HC_W-1:0]   hold_cnt;
  logic              in_flight;
  logic              hold_ok;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_idx;
  logic [DATA_W-1:0] shadow_q [N_WORDS];
`ifdef CSP_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  logic [DATA_W-1:0] rx_sum;
`endif

  assign s_ready = (state == IDLE) || (state == LOAD);
  assign busy    = (state != IDLE);
  assign hold_ok = (hold_cnt >= HOLD_LAST);

  always_comb begin
    buf_we  = 1'b0;
    buf_idx = '0;
    if (s_valid && s_ready) begin
      unique case (1'b1)
        state == IDLE: buf_we = 1'b1;
        state == LOAD: begin
          buf_we  = (idx < NW);
          buf_idx = idx[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Shadow array stays invisible to the filter until COMMIT
  always_ff @(posedge clk) begin
    if (buf_we) shadow_q[buf_idx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      hold_cnt    <= '0;
      in_flight   <= 1'b0;
      frame_hold  <= 1'b0;
      host_we     <= 1'b0;
      host_addr   <= '0;
      host_weight <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      hold_viol   <= 1'b0;
`ifdef CSP_LOADER_CHECKSUM_EN
      csum        <= '0;
      rx_sum      <= '0;
`endif
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      // Completion wins: the filter ignores valid while busy
      if (filt_out_valid) in_flight <= 1'b0;
      else if (frame_valid) in_flight <= 1'b1;
      if (state == COMMIT && frame_valid) hold_viol <= 1'b1;

      case (state)
        IDLE: begin
          if (s_valid) begin
            idx <= IDX_W'(1);
`ifdef CSP_LOADER_CHECKSUM_EN
            csum <= s_data;
`endif
            if (s_last) load_err <= 1'b1;
            else        state    <= LOAD;
          end
        end
        LOAD: begin
          if (s_valid) begin
            idx <= idx + 1'b1;
`ifdef CSP_LOADER_CHECKSUM_EN
            if (idx < NW) csum   <= csum + s_data;
            else          rx_sum <= s_data;
`endif
            if (idx == FINAL) begin
              if (s_last) begin
                state <= CHECK;
              end else begin
                load_err <= 1'b1;
                state    <= IDLE;
              end
            end else if (s_last) begin
              load_err <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        CHECK: begin
`ifdef CSP_LOADER_CHECKSUM_EN
          if (csum != rx_sum) begin
            load_err <= 1'b1;
            state    <= IDLE;
          end else begin
            frame_hold <= 1'b1;
            hold_cnt   <= '0;
            state      <= WAIT_IDLE;
          end
`else
          frame_hold <= 1'b1;
          hold_cnt   <= '0;
          state      <= WAIT_IDLE;
`endif
        end
        WAIT_IDLE: begin
          if (hold_ok && !in_flight && !frame_valid) begin
            host_we     <= 1'b1;
            host_addr   <= '0;
            host_weight <= shadow_q[0];
            state       <= COMMIT;
          end else if (!hold_ok) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        COMMIT: begin
          if (host_addr == LAST_ADDR) begin
            host_we   <= 1'b0;
            load_done <= 1'b1;
            state     <= DONE;
          end else begin
            host_addr   <= host_addr + 1'b1;
            host_weight <= shadow_q[host_addr + 1'b1];
          end
        end
        DONE: begin
          frame_hold  <= 1'b0;
          host_addr   <= '0;
          host_weight <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boreal_csp_weight_loader.sv
// Scoreboard bench for boreal_csp_weight_loader.
// Randomized blocks checked against a block-level reference model.
`timescale 1ns/1ps
module tb_boreal_csp_weight_loader;

  localparam int N_WORDS    = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 16;
  localparam int HOLD_SETUP = 2;
`ifdef CSP_LOADER_CHECKSUM_EN
  localparam int FINAL = N_WORDS;
  localparam bit CSUM  = 1'b1;
`else
  localparam int FINAL = N_WORDS - 1;
  localparam bit CSUM  = 1'b0;
`endif

  localparam int K_GOOD   = 0;
  localparam int K_EARLY  = 1;
  localparam int K_NOLAST = 2;
  localparam int K_BADSUM = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              frame_valid = 1'b0;
  logic              filt_out_valid = 1'b0;
  logic              s_ready;
  logic              frame_hold;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_weight;
  logic              load_done;
  logic              load_err;
  logic              hold_viol;
  logic              busy;

  boreal_csp_weight_loader #(
    .N_WORDS(N_WORDS),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .HOLD_SETUP(HOLD_SETUP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .frame_valid(frame_valid),
    .filt_out_valid(filt_out_valid),
    .frame_hold(frame_hold),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_weight(host_weight),
    .load_done(load_done),
    .load_err(load_err),
    .hold_viol(hold_viol),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_WR, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e          kind;
    int                addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t               sb[$];
  logic [DATA_W-1:0] blk_w[$];
  bit                blk_l[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int fov_cnt = 0;
  int last_word_cyc = 0;

  always @(posedge clk) cyc++;

  function automatic void check(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void expect_ev(input ev_kind_e k,
                                    input string nm);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got output event %0d, expected none",
               nm, int'(k));
    end else begin
      e = sb.pop_front();
      check({nm, " kind"}, int'(k), int'(e.kind));
      if (k == EV_WR && e.kind == EV_WR) begin
        check({nm, " addr"}, 32'(host_addr), e.addr);
        check({nm, " data"}, 32'(host_weight), 32'(e.data));
      end
    end
  endfunction

  // Build a block: ramp or random words, last flag by kind
  function automatic void make_block(input int kind, input int pos,
                                     input bit ramp);
    int n;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] v;
    blk_w.delete();
    blk_l.delete();
    if (kind == K_EARLY)
      n = (pos >= 0) ? pos + 1 : $urandom_range(0, FINAL - 1) + 1;
    else
      n = FINAL + 1;
    s = '0;
    for (int i = 0; i < n; i++) begin
      v = ramp ? DATA_W'((i + 1) * 256) : DATA_W'($urandom);
      if (CSUM && i == N_WORDS)
        v = (kind == K_BADSUM) ? s + 1'b1 : s;
      if (i < N_WORDS) s = s + v;
      blk_w.push_back(v);
      blk_l.push_back((kind != K_NOLAST) && (i == n - 1));
    end
  endfunction

  // Reference: framing and checksum rules over the whole block
  function automatic void model(input int stop);
    bit ok;
    int i;
    logic [DATA_W-1:0] s;
    ev_t e;
    s = '0;
    for (i = 0; i < blk_w.size(); i++)
      if (blk_l[i] || i == FINAL) break;
    ok = (i == FINAL) && (i < blk_w.size()) && blk_l[i];
    if (ok && CSUM) begin
      for (int k = 0; k < N_WORDS; k++) s = s + blk_w[k];
      ok = (s == blk_w[FINAL]);
    end
    if (!ok) begin
      e.kind = EV_ERR; e.addr = 0; e.data = '0;
      sb.push_back(e);
    end else begin
      for (int a = 0; a < N_WORDS && a < stop; a++) begin
        e.kind = EV_WR; e.addr = a; e.data = blk_w[a];
        sb.push_back(e);
      end
      if (stop >= N_WORDS) begin
        e.kind = EV_DONE; e.addr = 0; e.data = '0;
        sb.push_back(e);
      end
    end
  endfunction

  task automatic send_block(input int fv_at, input int fov_dly,
                            input bit gaps);
    for (int i = 0; i < blk_w.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = blk_w[i];
      s_last  = blk_l[i];
      if (i == fv_at) begin
        frame_valid = 1'b1;
        fov_cnt = fov_dly;
      end
      check("s_ready while loading", 32'(s_ready), 1);
      last_word_cyc = cyc;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last = 1'b0;
      frame_valid = 1'b0;
    end
  endtask

  task automatic run_block(input int kind, input int pos,
                           input bit ramp, input int fv_at,
                           input int fov_dly, input bit gaps,
                           input int stop);
    make_block(kind, pos, ramp);
    model(stop);
    send_block(fv_at, fov_dly, gaps);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || sb.size() != 0 || fov_cnt != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle reached", 32'(k < 300), 1);
    if (k >= 300) sb.delete();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_addr(input int a, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (host_we && host_addr == ADDR_W'(a)) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("commit address reached", 32'(hit), 1);
  endtask

  // Filter stand-in: completes a frame fov_cnt cycles after it starts
  initial begin
    forever begin
      @(posedge clk); #2;
      filt_out_valid = 1'b0;
      if (fov_cnt > 0) begin
        fov_cnt--;
        if (fov_cnt == 0) filt_out_valid = 1'b1;
      end
    end
  end

  // Monitor
  int last_wr_cyc = -100;
  int hold_run = 0;
  bit outstanding = 1'b0;
  bit prev_out = 1'b0;
  bit prev_fv = 1'b0;
  bit hv_exp = 1'b0;
  bit chk_hold_low = 1'b0;

  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      if (chk_hold_low) begin
        check("frame_hold after done", 32'(frame_hold), 0);
        chk_hold_low = 1'b0;
      end
      check("hold_viol", 32'(hold_viol), 32'(hv_exp));
      if (host_we) begin
        check("busy in commit", 32'(busy), 1);
        check("s_ready in commit", 32'(s_ready), 0);
        check("frame_hold in commit", 32'(frame_hold), 1);
        expect_ev(EV_WR, "write");
        if (host_addr == '0) begin
          check("min load-to-commit latency",
                32'(cyc >= last_word_cyc + 2 + HOLD_SETUP), 1);
          check("hold setup cycles",
                32'(hold_run >= HOLD_SETUP), 1);
          check("no frame in flight before commit",
                32'(prev_out || prev_fv), 0);
        end else begin
          check("write gap", 32'(cyc - last_wr_cyc), 1);
        end
        last_wr_cyc = cyc;
      end
      if (load_done) begin
        expect_ev(EV_DONE, "load_done");
        check("done after last write", 32'(cyc - last_wr_cyc), 1);
        chk_hold_low = 1'b1;
      end
      if (load_err) begin
        expect_ev(EV_ERR, "load_err");
        check("no write with err", 32'(host_we), 0);
      end
      hold_run = frame_hold ? hold_run + 1 : 0;
      hv_exp = rst ? 1'b0 : (hv_exp || (frame_valid && host_we));
      prev_out = outstanding;
      prev_fv = frame_valid;
      if (rst || filt_out_valid) outstanding = 1'b0;
      else if (frame_valid) outstanding = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int r;
    int kind;
    int fva;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset s_ready", 32'(s_ready), 1);
    check("reset busy", 32'(busy), 0);
    check("reset host_we", 32'(host_we), 0);
    check("reset frame_hold", 32'(frame_hold), 0);
    check("reset load_done", 32'(load_done), 0);
    check("reset load_err", 32'(load_err), 0);
    check("reset hold_viol", 32'(hold_viol), 0);
    check("reset host_addr", 32'(host_addr), 0);
    check("reset host_weight", 32'(host_weight), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp block, no frames
    run_block(K_GOOD, -1, 1'b1, -1, 0, 1'b0, 99);
    wait_idle();

    // Frame starts on the final word, completes 6 cycles later
    run_block(K_GOOD, -1, 1'b0, FINAL, 6, 1'b0, 99);
    wait_idle();

    // Early s_last at word 9, then a normal block
    run_block(K_EARLY, 9, 1'b0, -1, 0, 1'b0, 99);
    wait_idle();
    run_block(K_GOOD, -1, 1'b1, -1, 0, 1'b1, 99);
    wait_idle();

    // Missing s_last, and (if enabled) a bad checksum
    run_block(K_NOLAST, -1, 1'b0, -1, 0, 1'b0, 99);
    wait_idle();
    if (CSUM) begin
      run_block(K_BADSUM, -1, 1'b1, -1, 0, 1'b0, 99);
      wait_idle();
    end
    run_block(K_EARLY, 0, 1'b0, -1, 0, 1'b0, 99);
    wait_idle();

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 5);
      kind = (r < 3) ? K_GOOD : (r == 3) ? K_EARLY :
             (r == 4) ? K_NOLAST : (CSUM ? K_BADSUM : K_GOOD);
      fva = ($urandom_range(0, 2) == 0) ?
            $urandom_range(0, FINAL) : -1;
      run_block(kind, -1, 1'b0, fva, $urandom_range(1, 10),
                1'b1, 99);
      wait_idle();
    end

    // Frame forced during commit at addr 5
    check("hold_viol clear before", 32'(hold_viol), 0);
    run_block(K_GOOD, -1, 1'b0, -1, 0, 1'b0, 99);
    wait_addr(5, hit);
    if (hit) begin
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      fov_cnt = 3;
    end
    wait_idle();
    check("hold_viol sticky", 32'(hold_viol), 1);

    // Reset while committing addr 7
    run_block(K_GOOD, -1, 1'b0, -1, 0, 1'b0, 8);
    wait_addr(7, hit);
    if (hit) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst host_we", 32'(host_we), 0);
      check("rst s_ready", 32'(s_ready), 1);
      check("rst busy", 32'(busy), 0);
      check("rst load_done", 32'(load_done), 0);
      check("rst hold_viol", 32'(hold_viol), 0);
      check("rst frame_hold", 32'(frame_hold), 0);
    end
    wait_idle();
    run_block(K_GOOD, -1, 1'b0, -1, 0, 1'b1, 99);
    wait_idle();

    repeat (10) @(posedge clk);
    check("scoreboard drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

endmodule
